// File: rtl/mc_pkg.sv
// Multicycle controller shared definitions: FSM states, opcode/funct
// constants, ALU control and datapath mux encodings, control bundle.
package mc_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned ALUOP_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM2 = 2'b11;

    localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

    // aluop selects between fixed add, fixed sub and funct-driven decode
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic             iord;
        logic             irwrite;
        logic             memwrite;
        logic             regwrite;
        logic             regdst;
        logic             memtoreg;
        logic             alusrca;
        logic [SEL_W-1:0] alusrcb;
        logic [SEL_W-1:0] pcsrc;
        logic             pcwrite;
        logic             branch;
        logic             instr_done;
        logic             illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle.
//   master: datapath side (drives op/funct/zero, consumes controls)
//   slave : controller side (consumes op/funct/zero, drives controls)
interface mc_controller_if;
    import mc_pkg::*;

    logic [OP_W-1:0]      op;
    logic [FUNCT_W-1:0]   funct;
    logic                 zero;
    logic                 iord;
    logic                 irwrite;
    logic                 memwrite;
    logic                 regwrite;
    logic                 regdst;
    logic                 memtoreg;
    logic                 alusrca;
    logic [SEL_W-1:0]     alusrcb;
    logic [SEL_W-1:0]     pcsrc;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic                 pcen;
    logic                 instr_done;
    logic                 illegal;
    logic [STATE_W-1:0]   state;

    modport master (
        output op, funct, zero,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, aluctrl, pcen, instr_done, illegal, state
    );

    modport slave (
        input  op, funct, zero,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, aluctrl, pcen, instr_done, illegal, state
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU control decode.
//   aluop    : 00 add, 01 sub, 10 use funct
//   funct    : R-type function field
//   aluctrl  : ALU operation select
//   funct_ok : funct is a supported R-type function (independent of aluop)
module mc_aludec
    import mc_pkg::*;
(
    input  logic [ALUOP_W-1:0]   aluop,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUCTRL_W-1:0] aluctrl,
    output logic                 funct_ok
);

    logic [ALUCTRL_W-1:0] funct_ctrl;

    // funct field decode; unsupported codes fall back to add
    always_comb begin
        funct_ctrl = ALU_ADD;
        funct_ok   = 1'b1;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        aluctrl = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   aluctrl = ALU_SUB;
            ALUOP_FUNCT: aluctrl = funct_ctrl;
            default:     aluctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of mc_controller_if (op/funct/zero in;
//                mux selects, write enables, aluctrl, pcen, instr_done,
//                illegal and debug state out)
// Controls are decoded from the state register; only pcen also looks at
// the ALU zero flag.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit SUPPORT_ADDI = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.slave  bus
);

    state_t               state_q;
    state_t               state_d;
    ctrl_t                ctrl;
    logic [ALUOP_W-1:0]   aluop;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic                 funct_ok;
    logic                 op_legal;

    mc_aludec u_aludec (
        .aluop    (aluop),
        .funct    (bus.funct),
        .aluctrl  (aluctrl),
        .funct_ok (funct_ok)
    );

    // Opcode legality; R-type additionally requires a supported funct
    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            OP_RTYPE:                   op_legal = funct_ok;
            OP_ADDI:                    op_legal = SUPPORT_ADDI;
            default:                    op_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; unknown encodings and terminal states return to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (op_legal) begin
                    case (bus.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                if (bus.op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.op == OP_SW) begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; illegal opcodes report through illegal, not instr_done
    always_comb begin
        ctrl  = '0;
        aluop = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.pcsrc   = PC_ALU;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMM2;
                ctrl.illegal = ~op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg   = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                aluop        = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regdst     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_REG;
                ctrl.pcsrc      = PC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
                aluop           = ALUOP_SUB;
            end
            S_ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc      = PC_JUMP;
                ctrl.pcwrite    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
        // Reset holds FETCH selects but suppresses every enable and pulse
        if (reset) begin
            ctrl.irwrite    = 1'b0;
            ctrl.memwrite   = 1'b0;
            ctrl.regwrite   = 1'b0;
            ctrl.pcwrite    = 1'b0;
            ctrl.branch     = 1'b0;
            ctrl.instr_done = 1'b0;
            ctrl.illegal    = 1'b0;
        end
    end

    assign bus.iord       = ctrl.iord;
    assign bus.irwrite    = ctrl.irwrite;
    assign bus.memwrite   = ctrl.memwrite;
    assign bus.regwrite   = ctrl.regwrite;
    assign bus.regdst     = ctrl.regdst;
    assign bus.memtoreg   = ctrl.memtoreg;
    assign bus.alusrca    = ctrl.alusrca;
    assign bus.alusrcb    = ctrl.alusrcb;
    assign bus.pcsrc      = ctrl.pcsrc;
    assign bus.aluctrl    = aluctrl;
    assign bus.pcen       = ctrl.pcwrite | (ctrl.branch & bus.zero);
    assign bus.instr_done = ctrl.instr_done;
    assign bus.illegal    = ctrl.illegal;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected output vectors are
// queued with each instruction and compared cycle by cycle.
module tb_mc_controller;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mc_controller_if bus ();
    mc_controller_if bus_na ();

    mc_controller #(.SUPPORT_ADDI(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mc_controller #(.SUPPORT_ADDI(1'b0)) dut_na (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_na)
    );

    assign bus_na.op    = bus.op;
    assign bus_na.funct = bus.funct;
    assign bus_na.zero  = bus.zero;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctrl;
        logic       pcen;
        logic       done;
        logic       ill;
    } obs_t;

    obs_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st       = bus.state;
        o.iord     = bus.iord;
        o.irwrite  = bus.irwrite;
        o.memwrite = bus.memwrite;
        o.regwrite = bus.regwrite;
        o.regdst   = bus.regdst;
        o.memtoreg = bus.memtoreg;
        o.alusrca  = bus.alusrca;
        o.alusrcb  = bus.alusrcb;
        o.pcsrc    = bus.pcsrc;
        o.aluctrl  = bus.aluctrl;
        o.pcen     = bus.pcen;
        o.done     = bus.instr_done;
        o.ill      = bus.illegal;
        return o;
    endfunction

    function automatic obs_t mk(input logic [3:0] st, input logic iord, input logic irw,
                                input logic mw, input logic rw, input logic rd,
                                input logic m2r, input logic sa, input logic [1:0] b,
                                input logic [1:0] p, input logic [2:0] a, input logic pcen,
                                input logic done, input logic ill);
        obs_t o;
        o = '{st, iord, irw, mw, rw, rd, m2r, sa, b, p, a, pcen, done, ill};
        return o;
    endfunction

    // Expected per-state vectors
    function automatic obs_t e_fetch();  return mk(4'd0, 0,1,0,0,0,0,0, 2'b01,2'b00,3'b010, 1,0,0); endfunction
    function automatic obs_t e_decode(input logic ill); return mk(4'd1, 0,0,0,0,0,0,0, 2'b11,2'b00,3'b010, 0,0,ill); endfunction
    function automatic obs_t e_memadr(); return mk(4'd2, 0,0,0,0,0,0,1, 2'b10,2'b00,3'b010, 0,0,0); endfunction
    function automatic obs_t e_memrd();  return mk(4'd3, 1,0,0,0,0,0,0, 2'b00,2'b00,3'b010, 0,0,0); endfunction
    function automatic obs_t e_memwb();  return mk(4'd4, 0,0,0,1,0,1,0, 2'b00,2'b00,3'b010, 0,1,0); endfunction
    function automatic obs_t e_memwr();  return mk(4'd5, 1,0,1,0,0,0,0, 2'b00,2'b00,3'b010, 0,1,0); endfunction
    function automatic obs_t e_exec(input logic [2:0] a); return mk(4'd6, 0,0,0,0,0,0,1, 2'b00,2'b00,a, 0,0,0); endfunction
    function automatic obs_t e_aluwb();  return mk(4'd7, 0,0,0,1,1,0,0, 2'b00,2'b00,3'b010, 0,1,0); endfunction
    function automatic obs_t e_branch(input logic z); return mk(4'd8, 0,0,0,0,0,0,1, 2'b00,2'b01,3'b110, z,1,0); endfunction
    function automatic obs_t e_addiex(); return mk(4'd9, 0,0,0,0,0,0,1, 2'b10,2'b00,3'b010, 0,0,0); endfunction
    function automatic obs_t e_addiwb(); return mk(4'd10, 0,0,0,1,0,0,0, 2'b00,2'b00,3'b010, 0,1,0); endfunction
    function automatic obs_t e_jump();   return mk(4'd11, 0,0,0,0,0,0,0, 2'b00,2'b10,3'b010, 1,1,0); endfunction
    function automatic obs_t e_reset();  return mk(4'd0, 0,0,0,0,0,0,0, 2'b01,2'b00,3'b010, 0,0,0); endfunction

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        bus.op    = op;
        bus.funct = fn;
        bus.zero  = z;
    endtask

    // Pops one expected vector per cycle; starts and ends just after a negedge
    task automatic run_seq();
        obs_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            #1;
            check($sformatf("cyc%0d_st%0d", cyc, e.st), 32'(sample()), 32'(e));
            if (e.st == 4'd1 && bus.op == OP_ADDI)
                check("noaddi_illegal", 32'(bus_na.illegal), 32'd1);
            if (e.st == 4'd9)
                check("noaddi_to_fetch", 32'(bus_na.state), 32'd0);
            @(negedge clk);
            cyc++;
        end
    endtask

    localparam logic [5:0] FN_TAB [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
    localparam logic [2:0] AC_TAB [4] = '{3'b010, 3'b110, 3'b000, 3'b001};

    initial begin
        reset = 1'b1;
        set_instr(OP_LW, 6'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_hold", 32'(sample()), 32'(e_reset()));
        @(negedge clk);
        reset = 1'b0;

        // lw
        sb.push_back(e_fetch()); sb.push_back(e_decode(0)); sb.push_back(e_memadr());
        sb.push_back(e_memrd()); sb.push_back(e_memwb());
        run_seq();

        // R-type slt then the other funct codes
        set_instr(OP_RTYPE, 6'b101010, 1'b0);
        sb.push_back(e_fetch()); sb.push_back(e_decode(0));
        sb.push_back(e_exec(3'b111)); sb.push_back(e_aluwb());
        run_seq();
        for (int i = 0; i < 4; i++) begin
            set_instr(OP_RTYPE, FN_TAB[i], 1'b0);
            sb.push_back(e_fetch()); sb.push_back(e_decode(0));
            sb.push_back(e_exec(AC_TAB[i])); sb.push_back(e_aluwb());
            run_seq();
        end

        // beq taken, then not taken (FETCH pcen is 1 under either zero)
        set_instr(OP_BEQ, 6'd0, 1'b1);
        sb.push_back(e_fetch()); sb.push_back(e_decode(0)); sb.push_back(e_branch(1));
        run_seq();
        set_instr(OP_BEQ, 6'd0, 1'b0);
        sb.push_back(e_fetch()); sb.push_back(e_decode(0)); sb.push_back(e_branch(0));
        run_seq();

        // sw
        set_instr(OP_SW, 6'd0, 1'b1);
        sb.push_back(e_fetch()); sb.push_back(e_decode(0));
        sb.push_back(e_memadr()); sb.push_back(e_memwr());
        run_seq();

        // addi
        set_instr(OP_ADDI, 6'd0, 1'b0);
        sb.push_back(e_fetch()); sb.push_back(e_decode(0));
        sb.push_back(e_addiex()); sb.push_back(e_addiwb());
        run_seq();

        // j
        set_instr(OP_J, 6'd0, 1'b0);
        sb.push_back(e_fetch()); sb.push_back(e_decode(0)); sb.push_back(e_jump());
        run_seq();

        // illegal opcode, illegal funct
        set_instr(6'b111111, 6'd0, 1'b0);
        sb.push_back(e_fetch()); sb.push_back(e_decode(1));
        run_seq();
        set_instr(OP_RTYPE, 6'b000011, 1'b0);
        sb.push_back(e_fetch()); sb.push_back(e_decode(1));
        run_seq();

        // reset asserted mid-cycle in MEMRD
        set_instr(OP_LW, 6'd0, 1'b0);
        sb.push_back(e_fetch()); sb.push_back(e_decode(0)); sb.push_back(e_memadr());
        run_seq();
        #1;
        check("memrd_before_rst", 32'(sample()), 32'(e_memrd()));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", 32'(sample()), 32'(e_reset()));
        @(posedge clk);
        #1;
        check("rst_across_edge", 32'(sample()), 32'(e_reset()));
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(e_fetch()); sb.push_back(e_decode(0)); sb.push_back(e_memadr());
        sb.push_back(e_memrd()); sb.push_back(e_memwb());
        run_seq();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
